// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: assembles 32-bit little-endian instructions from four
// byte reads and hands them to the IF/ID register, with stall hold and jump redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IF_i,
    input  logic        jump_IF_i,
    input  logic [31:0] JBtaraddr_IF_i,
    output logic        mem_re_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_valid_i,
    output logic [31:0] inst_IFID_o,
    output logic [31:0] pc_IFID_o,
    output logic        valid_IFID_o
);

    // FETCH: reading bytes of pc_r; HOLD: full word parked behind a stalled slot;
    // DRAIN: redirect latched, waiting for the outstanding byte to come back.
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc_r, pc_n;
    logic [1:0]  idx_r, idx_n;
    logic [31:0] word_r, word_n;
    logic [31:0] tgt_r, tgt_n;
    logic        re_n;
    logic [31:0] addr_n;
    logic [31:0] inst_n, pcid_n;
    logic        vld_n;
    logic        ack;
    logic        slot_free;
    logic [31:0] idx_ext;

    // A byte only counts as returned while our request is actually up.
    assign ack       = mem_re_o & mem_valid_i;
    // The slot takes a new word if it is empty or its occupant leaves this edge.
    assign slot_free = ~valid_IFID_o | ~stall_IF_i;
    assign idx_ext   = {30'd0, idx_r};

    // Next-state, memory request and IF/ID update; jump overrides everything else.
    always_comb begin
        state_n = state;
        pc_n    = pc_r;
        idx_n   = idx_r;
        word_n  = word_r;
        tgt_n   = tgt_r;
        re_n    = mem_re_o;
        addr_n  = mem_addr_o;
        inst_n  = inst_IFID_o;
        pcid_n  = pc_IFID_o;
        vld_n   = valid_IFID_o;

        if (jump_IF_i) begin
            inst_n = 32'd0;
            pcid_n = 32'd0;
            vld_n  = 1'b0;
            idx_n  = 2'd0;
            if (!mem_re_o || mem_valid_i) begin
                // Nothing in flight (or it lands now and is dropped): go straight to target.
                state_n = FETCH;
                pc_n    = JBtaraddr_IF_i;
                re_n    = 1'b1;
                addr_n  = JBtaraddr_IF_i;
            end else begin
                // Request must stay up until acknowledged, so finish it first.
                state_n = DRAIN;
                tgt_n   = JBtaraddr_IF_i;
            end
        end else begin
            case (state)
                FETCH: begin
                    re_n   = 1'b1;
                    addr_n = pc_r + idx_ext;
                    if (slot_free) begin
                        inst_n = 32'd0;
                        vld_n  = 1'b0;
                    end
                    if (ack) begin
                        if (idx_r == 2'd3) begin
                            word_n = {mem_data_i, word_r[23:0]};
                            idx_n  = 2'd0;
                            if (slot_free) begin
                                inst_n = word_n;
                                pcid_n = pc_r;
                                vld_n  = 1'b1;
                                pc_n   = pc_r + 32'd4;
                                addr_n = pc_r + 32'd4;
                            end else begin
                                state_n = HOLD;
                                re_n    = 1'b0;
                            end
                        end else begin
                            word_n[{idx_r, 3'b000} +: 8] = mem_data_i;
                            idx_n  = idx_r + 2'd1;
                            addr_n = pc_r + idx_ext + 32'd1;
                        end
                    end
                end
                HOLD: begin
                    re_n = 1'b0;
                    if (!stall_IF_i) begin
                        inst_n  = word_r;
                        pcid_n  = pc_r;
                        vld_n   = 1'b1;
                        pc_n    = pc_r + 32'd4;
                        idx_n   = 2'd0;
                        state_n = FETCH;
                        re_n    = 1'b1;
                        addr_n  = pc_r + 32'd4;
                    end
                end
                DRAIN: begin
                    // IF/ID was flushed on the jump and stays empty until the target word.
                    if (ack) begin
                        pc_n    = tgt_r;
                        idx_n   = 2'd0;
                        state_n = FETCH;
                        re_n    = 1'b1;
                        addr_n  = tgt_r;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc_r         <= RESET_PC;
            idx_r        <= 2'd0;
            word_r       <= 32'd0;
            tgt_r        <= 32'd0;
            mem_re_o     <= 1'b0;
            mem_addr_o   <= 32'd0;
            inst_IFID_o  <= 32'd0;
            pc_IFID_o    <= 32'd0;
            valid_IFID_o <= 1'b0;
        end else begin
            state        <= state_n;
            pc_r         <= pc_n;
            idx_r        <= idx_n;
            word_r       <= word_n;
            tgt_r        <= tgt_n;
            mem_re_o     <= re_n;
            mem_addr_o   <= addr_n;
            inst_IFID_o  <= inst_n;
            pc_IFID_o    <= pcid_n;
            valid_IFID_o <= vld_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle-exact scenarios plus a randomized run
// checked against instruction-stream rules (sequential pcs, jump targets, stall hold).
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, jump;
    logic [31:0] tgt;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic [31:0] inst, pc;
    logic        valid;

    // second instance exercises the top-of-memory reset PC with a zero-latency memory
    logic        re2;
    logic [31:0] addr2;
    logic [7:0]  data2;
    logic        valid2_in;
    logic [31:0] inst2, pc2;
    logic        vld2;

    if_fetch_unit u_dut (
        .clk(clk), .rst(rst), .stall_IF_i(stall), .jump_IF_i(jump), .JBtaraddr_IF_i(tgt),
        .mem_re_o(mem_re), .mem_addr_o(mem_addr), .mem_data_i(mem_data), .mem_valid_i(mem_valid),
        .inst_IFID_o(inst), .pc_IFID_o(pc), .valid_IFID_o(valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk(clk), .rst(rst), .stall_IF_i(1'b0), .jump_IF_i(1'b0), .JBtaraddr_IF_i(32'd0),
        .mem_re_o(re2), .mem_addr_o(addr2), .mem_data_i(data2), .mem_valid_i(valid2_in),
        .inst_IFID_o(inst2), .pc_IFID_o(pc2), .valid_IFID_o(vld2)
    );

    int tests = 0;
    int fails = 0;

    // memory responder state
    int wait_cnt = 0;
    int cur_lat  = 0;
    int fixed_lat = 0;
    bit rand_lat = 1'b0;

    // scoreboard state
    bit          sb_on = 1'b0;
    logic [31:0] exp_pc;
    int          consumed = 0;

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'd0) return 8'h13;
        if (a == 32'd1) return 8'h05;
        if (a == 32'd2) return 8'h10;
        if (a == 32'd3) return 8'h00;
        h = (a ^ 32'hA5A5_0000) * 32'h9E37_79B1;
        return h[31:24] ^ h[15:8];
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response at negedge, take the edge, update responder
    // and run the stream checks on the new outputs.
    task automatic cycle();
        logic        p_valid, p_stall, p_jump, p_re, p_ack, p_rst;
        logic [31:0] p_inst, p_pc, p_addr, p_tgt;
        if (mem_re && wait_cnt >= cur_lat) begin
            mem_valid = 1'b1;
            mem_data  = mbyte(mem_addr);
        end else begin
            mem_valid = 1'b0;
            mem_data  = 8'($urandom);
        end
        valid2_in = re2;
        data2     = re2 ? mbyte(addr2) : 8'($urandom);
        p_valid = valid; p_stall = stall; p_jump = jump; p_re = mem_re;
        p_ack = mem_valid; p_rst = rst; p_inst = inst; p_pc = pc;
        p_addr = mem_addr; p_tgt = tgt;
        @(posedge clk);
        @(negedge clk);
        if (p_rst || p_ack || !p_re) begin
            wait_cnt = 0;
            cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end else begin
            wait_cnt++;
        end
        if (sb_on && !p_rst) begin
            if (p_re && !p_ack) begin
                chk("req_held_re", 32'(mem_re), 32'd1);
                chk("req_held_addr", mem_addr, p_addr);
            end
            if (p_jump) begin
                chk("jump_flush", 32'(valid), 32'd0);
                exp_pc = p_tgt;
            end else if (p_valid && p_stall) begin
                chk("stall_hold_v", 32'(valid), 32'd1);
                chk("stall_hold_inst", inst, p_inst);
                chk("stall_hold_pc", pc, p_pc);
            end else if (valid) begin
                chk("seq_pc", pc, exp_pc);
                chk("seq_inst", inst, mword(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end else begin
                chk("bubble_inst", inst, 32'd0);
            end
        end
        jump = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_re"}, 32'(mem_re), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_re2"}, 32'(re2), 32'd0);
        chk({tag, "_vld2"}, 32'(vld2), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; jump = 1'b0;
        cycle();
        rst = 1'b0;
        chk_reset_outputs("reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; stall = 1'b0; jump = 1'b0; tgt = 32'd0;
        mem_valid = 1'b0; mem_data = 8'd0; valid2_in = 1'b0; data2 = 8'd0;
        @(negedge clk);

        // ---- Zero-latency memory, first words, plus wrap on the second instance ----
        rand_lat = 1'b0; fixed_lat = 0;
        do_reset();
        cycle();
        chk("t1_re_e1", 32'(mem_re), 32'd1);
        chk("t1_addr_e1", mem_addr, 32'd0);
        chk("t5_addr2_e1", addr2, 32'hFFFF_FFFC);
        for (int e = 2; e <= 4; e++) begin
            cycle();
            chk("t1_novalid", 32'(valid), 32'd0);
        end
        cycle();
        chk("t1_inst0", inst, 32'h0010_0513);
        chk("t1_pc0", pc, 32'd0);
        chk("t1_valid0", 32'(valid), 32'd1);
        chk("t5_pc2", pc2, 32'hFFFF_FFFC);
        chk("t5_inst2", inst2, mword(32'hFFFF_FFFC));
        chk("t5_vld2", 32'(vld2), 32'd1);
        chk("t5_addr2_wrap", addr2, 32'd0);
        for (int e = 6; e <= 8; e++) begin
            cycle();
            chk("t1_bubble_v", 32'(valid), 32'd0);
            chk("t1_bubble_i", inst, 32'd0);
        end
        cycle();
        chk("t1_pc1", pc, 32'd4);
        chk("t1_inst1", inst, mword(32'd4));
        chk("t1_valid1", 32'(valid), 32'd1);
        chk("t5_pc2_next", pc2, 32'd0);
        chk("t5_inst2_next", inst2, 32'h0010_0513);

        // rst pulse in the middle of a word
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        for (int e = 1; e <= 5; e++) cycle();
        chk("restart_pc", pc, 32'd0);
        chk("restart_valid", 32'(valid), 32'd1);
        chk("restart_inst", inst, 32'h0010_0513);
        chk("restart_pc2", pc2, 32'hFFFF_FFFC);
        chk("restart_vld2", 32'(vld2), 32'd1);

        // ---- Stall holds IF/ID, second word parks, release forwards it ----
        stall = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            chk("t2_hold_pc", pc, 32'd0);
            chk("t2_hold_v", 32'(valid), 32'd1);
            chk("t2_hold_inst", inst, 32'h0010_0513);
            chk("t2_re", 32'(mem_re), (k >= 4) ? 32'd0 : 32'd1);
        end
        stall = 1'b0;
        cycle();
        chk("t2_rel_pc", pc, 32'd4);
        chk("t2_rel_inst", inst, mword(32'd4));
        chk("t2_rel_v", 32'(valid), 32'd1);
        chk("t2_rel_re", 32'(mem_re), 32'd1);
        chk("t2_rel_addr", mem_addr, 32'd8);

        // ---- Latency 2, jump while byte1 outstanding -> drain ----
        fixed_lat = 2;
        do_reset();
        n = 0;
        while (!(mem_re && mem_addr == 32'd1 && wait_cnt < cur_lat) && n < 40) begin
            cycle(); n++;
        end
        chk("t3_reach_byte1", 32'(n < 40), 32'd1);
        jump = 1'b1; tgt = 32'h100;
        cycle();
        chk("t3_flush_v", 32'(valid), 32'd0);
        chk("t3_drain_re", 32'(mem_re), 32'd1);
        chk("t3_drain_addr", mem_addr, 32'd1);
        n = 0;
        while (mem_addr == 32'd1 && n < 10) begin
            cycle(); n++;
            if (mem_addr == 32'd1) chk("t3_drain_re_hold", 32'(mem_re), 32'd1);
        end
        chk("t3_redirect_addr", mem_addr, 32'h100);
        n = 0;
        while (!valid && n < 40) begin cycle(); n++; end
        chk("t3_first_pc", pc, 32'h100);
        chk("t3_first_inst", inst, mword(32'h100));

        // ---- Jump over a parked word, then back-to-back jumps during drain ----
        fixed_lat = 0;
        do_reset();
        stall = 1'b1;
        for (int k = 1; k <= 9; k++) cycle();
        chk("t4_parked_re", 32'(mem_re), 32'd0);
        chk("t4_parked_pc", pc, 32'd0);
        fixed_lat = 2;
        jump = 1'b1; tgt = 32'h200;
        cycle();
        chk("t4_flush_v", 32'(valid), 32'd0);
        chk("t4_flush_pc", pc, 32'd0);
        chk("t4_jmp_addr", mem_addr, 32'h200);
        stall = 1'b0;
        jump = 1'b1; tgt = 32'h40;
        cycle();
        chk("t4_drain_addr_a", mem_addr, 32'h200);
        jump = 1'b1; tgt = 32'h80;
        cycle();
        chk("t4_drain_addr_b", mem_addr, 32'h200);
        n = 0;
        while (!valid && n < 40) begin cycle(); n++; end
        chk("t4_latest_pc", pc, 32'h80);
        chk("t4_latest_inst", inst, mword(32'h80));

        // ---- Randomized traffic against stream rules ----
        rand_lat = 1'b1;
        do_reset();
        sb_on = 1'b1;
        exp_pc = 32'd0;
        for (int c = 0; c < 2000; c++) begin
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) begin
                jump = 1'b1;
                tgt  = $urandom;
            end
            cycle();
        end
        sb_on = 1'b0;
        chk("rand_progress", 32'(consumed >= 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
